operand_scoreboard: RTL and testbench

- Decode/operand-fetch stage directly upstream of the register file read ports.
- Tracks in-flight writes to each general-purpose register, stalls instructions whose sources are still pending, and captures RA/RB into a one-entry interstage buffer feeding the ALU stage.
- The writeback stage reports completed writes via wb_valid/wb_Rdst, which is the same event as the register file's RF_WRITE.

---
 rtl/operand_scoreboard.sv | 122 ++++++++++++
 tb/tb_operand_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_scoreboard.sv
// Decode/operand-fetch scoreboard: per-register in-flight write counters, RAW/WAW
// stall generation and a one-entry operand buffer. Optional: SCOREBOARD_WB_BYPASS_EN.
module operand_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [ADDR_W-1:0]  issue_Rsrc1,
  input  logic [ADDR_W-1:0]  issue_Rsrc2,
  input  logic               issue_use1,
  input  logic               issue_use2,
  input  logic               issue_writes,
  input  logic [ADDR_W-1:0]  issue_Rdst,
  output logic               issue_ready,
  input  logic [DATA_W-1:0]  RA_in,
  input  logic [DATA_W-1:0]  RB_in,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_Rdst,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               op_valid,
  output logic [DATA_W-1:0]  RA_q,
  output logic [DATA_W-1:0]  RB_q,
  output logic [ADDR_W-1:0]  op_Rdst,
  output logic               op_writes,
  output logic               err_underflow,
  output logic [STALL_W-1:0] stall_cycles
);

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];

  logic byp1, byp2;
  logic pend1, pend2, full_dst, hazard, accept;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The last outstanding write to a source retires this cycle: take wb_data directly.
  assign byp1 = wb_valid && (wb_Rdst == issue_Rsrc1) && (cnt[issue_Rsrc1] == CNT_W'(1));
  assign byp2 = wb_valid && (wb_Rdst == issue_Rsrc2) && (cnt[issue_Rsrc2] == CNT_W'(1));
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign pend1    = (cnt[issue_Rsrc1] != '0) && !byp1;
  assign pend2    = (cnt[issue_Rsrc2] != '0) && !byp2;
  assign full_dst = (cnt[issue_Rdst] == '1);
  assign hazard   = (issue_use1 && pend1) || (issue_use2 && pend2) ||
                    (issue_writes && full_dst);

  assign issue_ready = !hazard && !flush && (!op_valid || ex_ready);
  assign accept      = issue_valid && issue_ready;

  // Net counter update: increments and decrements combine; a result below zero clamps at 0.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      logic              inc, dwb, dfl;
      logic [CNT_W:0]    up;
      logic [CNT_W:0]    down;
      inc  = accept && issue_writes && (issue_Rdst == ADDR_W'(i));
      dwb  = wb_valid && (wb_Rdst == ADDR_W'(i));
      dfl  = flush && op_valid && op_writes && (op_Rdst == ADDR_W'(i));
      up   = {1'b0, cnt[i]} + {{CNT_W{1'b0}}, inc};
      down = {{CNT_W{1'b0}}, dwb} + {{CNT_W{1'b0}}, dfl};
      if (up >= down)
        cnt_nxt[i] = CNT_W'(up - down);
      else
        cnt_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid  <= 1'b0;
      RA_q      <= '0;
      RB_q      <= '0;
      op_Rdst   <= '0;
      op_writes <= 1'b0;
    end else if (flush) begin
      op_valid  <= 1'b0;
    end else if (accept) begin
      op_valid  <= 1'b1;
      RA_q      <= byp1 ? wb_data : RA_in;
      RB_q      <= byp2 ? wb_data : RB_in;
      op_Rdst   <= issue_Rdst;
      op_writes <= issue_writes;
    end else if (op_valid && ex_ready) begin
      op_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (wb_valid && (cnt[wb_Rdst] == '0))
        err_underflow <= 1'b1;
      if (issue_valid && !issue_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed self-checking bench for operand_scoreboard (default parameters).
module tb_operand_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use1, issue_use2, issue_writes;
  logic [4:0]  issue_Rsrc1, issue_Rsrc2, issue_Rdst;
  logic        issue_ready;
  logic [31:0] RA_in, RB_in;
  logic        wb_valid;
  logic [4:0]  wb_Rdst;
  logic [31:0] wb_data;
  logic        flush, ex_ready;
  logic        op_valid;
  logic [31:0] RA_q, RB_q;
  logic [4:0]  op_Rdst;
  logic        op_writes, err_underflow;
  logic [15:0] stall_cycles;

  int n_total = 0;
  int n_pass  = 0;

  operand_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .CNT_W(2), .STALL_W(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_Rsrc1(issue_Rsrc1), .issue_Rsrc2(issue_Rsrc2),
    .issue_use1(issue_use1), .issue_use2(issue_use2), .issue_writes(issue_writes),
    .issue_Rdst(issue_Rdst), .issue_ready(issue_ready),
    .RA_in(RA_in), .RB_in(RB_in),
    .wb_valid(wb_valid), .wb_Rdst(wb_Rdst), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready),
    .op_valid(op_valid), .RA_q(RA_q), .RB_q(RB_q), .op_Rdst(op_Rdst),
    .op_writes(op_writes), .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_use1 = 0; issue_use2 = 0; issue_writes = 0;
    issue_Rsrc1 = 0; issue_Rsrc2 = 0; issue_Rdst = 0;
    RA_in = 0; RB_in = 0; wb_valid = 0; wb_Rdst = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic issue_write(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1; issue_writes = 1; issue_Rdst = rd;
    issue_use1 = 0; issue_use2 = 0; RA_in = a; RB_in = b;
  endtask

  task automatic issue_read1(input logic [4:0] rs, input logic [31:0] a);
    issue_valid = 1; issue_writes = 0; issue_use1 = 1; issue_Rsrc1 = rs;
    issue_use2 = 0; RA_in = a;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_op_valid"}, 64'(op_valid), 0);
    chk({tag, "_RA_q"}, 64'(RA_q), 0);
    chk({tag, "_RB_q"}, 64'(RB_q), 0);
    chk({tag, "_op_Rdst"}, 64'(op_Rdst), 0);
    chk({tag, "_op_writes"}, 64'(op_writes), 0);
    chk({tag, "_err"}, 64'(err_underflow), 0);
    chk({tag, "_stall"}, 64'(stall_cycles), 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #3;
    check_all_zero("rst0");
    tick();
    reset = 0;
    #1 chk("idle_ready", 64'(issue_ready), 1);

    // RAW on R5: write, then read stalls until writeback, accepted the cycle after.
    tick();
    issue_write(5, 32'h11, 32'h22);
    #1 chk("a_w5_ready", 64'(issue_ready), 1);
    tick();
    chk("a_op_valid", 64'(op_valid), 1);
    chk("a_RA_q", 64'(RA_q), 32'h11);
    chk("a_RB_q", 64'(RB_q), 32'h22);
    chk("a_op_Rdst", 64'(op_Rdst), 5);
    chk("a_op_writes", 64'(op_writes), 1);
    issue_read1(5, 32'h55);
    #1 chk("a_raw_stall", 64'(issue_ready), 0);
    tick();
    chk("a_stall1", 64'(stall_cycles), 1);
    chk("a_drained", 64'(op_valid), 0);
    #1 chk("a_raw_stall2", 64'(issue_ready), 0);
    tick();
    chk("a_stall2", 64'(stall_cycles), 2);
    wb_valid = 1; wb_Rdst = 5;
    #1 chk("a_wb_cycle_stall", 64'(issue_ready), 0);
    tick();
    chk("a_stall3", 64'(stall_cycles), 3);
    wb_valid = 0;
    #1 chk("a_after_wb_ready", 64'(issue_ready), 1);
    tick();
    chk("a_acc_valid", 64'(op_valid), 1);
    chk("a_acc_RA", 64'(RA_q), 32'h55);
    chk("a_acc_writes", 64'(op_writes), 0);
    chk("a_stall_hold", 64'(stall_cycles), 3);

    // Three writes to R7 fill the counter; the fourth stalls until a writeback retires one.
    issue_write(7, 32'h71, 0);
    #1 chk("b_w1", 64'(issue_ready), 1);
    tick();
    RA_in = 32'h72;
    #1 chk("b_w2", 64'(issue_ready), 1);
    tick();
    RA_in = 32'h73;
    #1 chk("b_w3", 64'(issue_ready), 1);
    tick();
    chk("b_w3_RA", 64'(RA_q), 32'h73);
    RA_in = 32'h74;
    #1 chk("b_w4_full", 64'(issue_ready), 0);
    tick();
    chk("b_stall4", 64'(stall_cycles), 4);
    wb_valid = 1; wb_Rdst = 7;
    #1 chk("b_w4_wb_cycle", 64'(issue_ready), 0);
    tick();
    chk("b_stall5", 64'(stall_cycles), 5);
    wb_valid = 0;
    #1 chk("b_w4_ready", 64'(issue_ready), 1);
    tick();
    chk("b_w4_RA", 64'(RA_q), 32'h74);
    issue_valid = 0; issue_writes = 0;
    wb_valid = 1; wb_Rdst = 7;
    tick(); tick(); tick();
    wb_valid = 0;
    chk("b_no_err", 64'(err_underflow), 0);
    issue_read1(7, 32'h77);
    #1 chk("b_r7_free", 64'(issue_ready), 1);
    tick();
    chk("b_r7_RA", 64'(RA_q), 32'h77);

    // Back-pressure: buffer holds while ex_ready=0, then is replaced in one cycle.
    issue_valid = 1; issue_use1 = 0; issue_writes = 0; issue_Rdst = 2;
    RA_in = 32'hAAAA; RB_in = 32'hBBBB;
    tick();
    ex_ready = 0;
    RA_in = 32'h1111; RB_in = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      #1 chk("c_hold_ready", 64'(issue_ready), 0);
      tick();
      chk("c_hold_RA", 64'(RA_q), 32'hAAAA);
      chk("c_hold_RB", 64'(RB_q), 32'hBBBB);
    end
    chk("c_hold_valid", 64'(op_valid), 1);
    chk("c_stall9", 64'(stall_cycles), 9);
    ex_ready = 1; RA_in = 32'hCCCC;
    #1 chk("c_replace_ready", 64'(issue_ready), 1);
    tick();
    chk("c_replace_valid", 64'(op_valid), 1);
    chk("c_replace_RA", 64'(RA_q), 32'hCCCC);

    // Flush a buffered write to R9: its counter is released.
    issue_write(9, 32'h99, 0);
    tick();
    chk("d_op_Rdst", 64'(op_Rdst), 9);
    idle_inputs();
    ex_ready = 0; flush = 1;
    #1 chk("d_flush_ready", 64'(issue_ready), 0);
    tick();
    chk("d_flushed", 64'(op_valid), 0);
    flush = 0; ex_ready = 1;
    issue_read1(9, 32'h909);
    #1 chk("d_r9_free", 64'(issue_ready), 1);
    tick();
    chk("d_r9_RA", 64'(RA_q), 32'h909);
    chk("d_stall_same", 64'(stall_cycles), 9);

    // Writeback racing a dependent read of R4.
    issue_write(4, 0, 0);
    tick();
    issue_read1(4, 32'h1234);
    wb_valid = 1; wb_Rdst = 4; wb_data = 32'hDEADBEEF;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 chk("e_bypass_ready", 64'(issue_ready), 1);
    tick();
    chk("e_bypass_RA", 64'(RA_q), 32'hDEADBEEF);
    wb_valid = 0;
`else
    #1 chk("e_nobyp_stall", 64'(issue_ready), 0);
    tick();
    chk("e_stall10", 64'(stall_cycles), 10);
    wb_valid = 0;
    #1 chk("e_nobyp_ready", 64'(issue_ready), 1);
    tick();
    chk("e_nobyp_RA", 64'(RA_q), 32'h1234);
`endif

    // Writeback with nothing outstanding raises the sticky error.
    idle_inputs();
    wb_valid = 1; wb_Rdst = 0;
    tick();
    wb_valid = 0;
    tick();
    chk("f_err_sticky", 64'(err_underflow), 1);

    // Asynchronous reset mid-stream with two writes pending to R3 and a full buffer.
    issue_write(3, 32'h31, 32'h32);
    tick(); tick();
    chk("g_pre_valid", 64'(op_valid), 1);
    issue_valid = 0; issue_writes = 0;
    #2 reset = 1;
    #1 check_all_zero("g_rst");
    tick();
    reset = 0;
    issue_read1(3, 32'h333);
    #1 chk("g_r3_free", 64'(issue_ready), 1);
    tick();
    chk("g_r3_RA", 64'(RA_q), 32'h333);
    chk("g_r3_valid", 64'(op_valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
